// File: rtl/lsu_ram_if_pkg.sv
// lsu_ram_if_pkg: shared definitions for the MEM-stage load/store adapter.
// Holds the access-size codes, the adapter FSM state encoding, the byte-lane
// masks, and small helpers for the lane mask and word-crossing detection.
package lsu_ram_if_pkg;

  // Access size codes as carried on req_size
  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  // Byte-lane masks for an access starting at lane 0
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Unshifted lane mask for a size code; the illegal size selects no lanes.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SIZE_B:  m = MASK_B;
      SIZE_H:  m = MASK_H;
      SIZE_W:  m = MASK_W;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // True when the access touches bytes in two consecutive RAM words.
  function automatic logic is_cross(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_H) && (off == 2'd3)) || ((size == SIZE_W) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for lsu_ram_if.
//   size, off, is_unsigned : access size code, byte offset in word, zero-extend
//   wdata                  : right-justified store data
//   hi, lo                 : RAM words holding the upper / lower part of a load
//   sel_lo, wdata_lo       : lane mask and lane-shifted data for the first word
//   sel_hi, wdata_hi       : lane mask and lane-shifted data for the second word
//   rdata                  : load data aligned to bit 0 and sign/zero extended
module lsu_lane_align
  import lsu_ram_if_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    size,
  input  logic [1:0]    off,
  input  logic          is_unsigned,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  output logic [3:0]    sel_lo,
  output logic [3:0]    sel_hi,
  output logic [DW-1:0] wdata_lo,
  output logic [DW-1:0] wdata_hi,
  output logic [DW-1:0] rdata
);

  logic [7:0]      sel_wide_s;
  logic [2*DW-1:0] wdata_wide_s;
  logic [DW-1:0]   rd_shift_s;

  // Shift mask and data across a two-word window; the upper half is what
  // spills into the next word (mask >> (4-o), wdata >> 8*(4-o)).
  always_comb begin
    sel_wide_s   = {4'b0000, size_mask(size)} << off;
    wdata_wide_s = {{DW{1'b0}}, wdata} << {off, 3'b000};
    rd_shift_s   = DW'({hi, lo} >> {off, 3'b000});
  end

  assign sel_lo   = sel_wide_s[3:0];
  assign sel_hi   = sel_wide_s[7:4];
  assign wdata_lo = wdata_wide_s[DW-1:0];
  assign wdata_hi = wdata_wide_s[2*DW-1:DW];

  // Truncate the aligned load to its size, then extend.
  always_comb begin
    case (size)
      SIZE_B: begin
        if (is_unsigned) rdata = {{(DW-8){1'b0}}, rd_shift_s[7:0]};
        else             rdata = {{(DW-8){rd_shift_s[7]}}, rd_shift_s[7:0]};
      end
      SIZE_H: begin
        if (is_unsigned) rdata = {{(DW-16){1'b0}}, rd_shift_s[15:0]};
        else             rdata = {{(DW-16){rd_shift_s[15]}}, rd_shift_s[15:0]};
      end
      SIZE_W:  rdata = rd_shift_s;
      default: rdata = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/lsu_ram_if.sv
// lsu_ram_if: MEM-stage load/store adapter in front of the single-port data RAM.
// Accepts one byte-addressed request per valid/ready handshake, runs one RAM
// cycle (two if the access crosses a word), and returns a one-cycle response.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_we/size/unsigned     : store flag, size code, load zero-extend
//   req_addr, req_wdata      : byte address, right-justified store data
//   rsp_valid/rdata/err      : response pulse, extended load data, error flag
//   ram_addr/wdata/sel/we    : RAM word index, lane data, lane mask, write strobe
//   ram_rdata                : combinational RAM read data
module lsu_ram_if
  import lsu_ram_if_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic [3:0]    ram_sel,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW-3:0] WIDX_ONE = {{(AW-3){1'b0}}, 1'b1};

  state_e        state_r;
  logic [1:0]    size_r;
  logic [1:0]    off_r;
  logic          we_r;
  logic          uns_r;
  logic          cross_r;
  logic [DW-1:0] wdata_r;
  logic [AW-3:0] widx_r;
  logic [DW-1:0] lo_r;

  logic          rsp_valid_r;
  logic          rsp_err_r;
  logic [DW-1:0] rsp_rdata_r;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_wdata_r;
  logic [3:0]    ram_sel_r;
  logic          ram_we_r;

  logic          req_ready_s;
  logic          accept_s;
  logic          req_cross_s;
  logic          req_bad_s;
  logic [1:0]    la_size_s;
  logic [1:0]    la_off_s;
  logic          la_uns_s;
  logic [DW-1:0] la_wdata_s;
  logic [DW-1:0] la_lo_s;
  logic [3:0]    la_sel_lo_s;
  logic [3:0]    la_sel_hi_s;
  logic [DW-1:0] la_wdata_lo_s;
  logic [DW-1:0] la_wdata_hi_s;
  logic [DW-1:0] la_rdata_s;

  assign req_ready_s = (state_r == ST_IDLE) || (state_r == ST_RESP);
  assign accept_s    = req_valid && req_ready_s;
  assign req_cross_s = is_cross(req_size, req_addr[1:0]);
  assign req_bad_s   = (req_size == SIZE_ILL) || (req_cross_s && (MISALIGN_EN == 0));

  // Lane steering sees the live request while a new one can be accepted and
  // the captured request during the RAM cycles; the low word comes straight
  // from the RAM in ACC1 and from the captured copy in ACC2.
  always_comb begin
    if (req_ready_s) begin
      la_size_s  = req_size;
      la_off_s   = req_addr[1:0];
      la_uns_s   = req_unsigned;
      la_wdata_s = req_wdata;
    end else begin
      la_size_s  = size_r;
      la_off_s   = off_r;
      la_uns_s   = uns_r;
      la_wdata_s = wdata_r;
    end
    if (state_r == ST_ACC2) la_lo_s = lo_r;
    else                    la_lo_s = ram_rdata;
  end

  lsu_lane_align #(.DW(DW)) u_align (
    .size        (la_size_s),
    .off         (la_off_s),
    .is_unsigned (la_uns_s),
    .wdata       (la_wdata_s),
    .hi          (ram_rdata),
    .lo          (la_lo_s),
    .sel_lo      (la_sel_lo_s),
    .sel_hi      (la_sel_hi_s),
    .wdata_lo    (la_wdata_lo_s),
    .wdata_hi    (la_wdata_hi_s),
    .rdata       (la_rdata_s)
  );

  // Adapter FSM; RAM and response outputs are registered on entry to the
  // state that presents them and return to zero everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      cross_r     <= 1'b0;
      wdata_r     <= {DW{1'b0}};
      widx_r      <= {(AW-2){1'b0}};
      lo_r        <= {DW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DW{1'b0}};
      ram_addr_r  <= {AW{1'b0}};
      ram_wdata_r <= {DW{1'b0}};
      ram_sel_r   <= 4'b0000;
      ram_we_r    <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DW{1'b0}};
      ram_addr_r  <= {AW{1'b0}};
      ram_wdata_r <= {DW{1'b0}};
      ram_sel_r   <= 4'b0000;
      ram_we_r    <= 1'b0;
      case (state_r)
        ST_IDLE, ST_RESP: begin
          if (accept_s) begin
            size_r  <= req_size;
            off_r   <= req_addr[1:0];
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            cross_r <= req_cross_s;
            wdata_r <= req_wdata;
            widx_r  <= req_addr[AW-1:2];
            if (req_bad_s) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
            end else begin
              state_r     <= ST_ACC1;
              ram_addr_r  <= {2'b00, req_addr[AW-1:2]};
              ram_sel_r   <= la_sel_lo_s;
              ram_wdata_r <= la_wdata_lo_s;
              ram_we_r    <= req_we;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACC1: begin
          lo_r <= ram_rdata;
          if (cross_r) begin
            state_r     <= ST_ACC2;
            // Word index wraps within AW-2 bits; top two address bits stay 0.
            ram_addr_r  <= {2'b00, widx_r + WIDX_ONE};
            ram_sel_r   <= la_sel_hi_s;
            ram_wdata_r <= la_wdata_hi_s;
            ram_we_r    <= we_r;
          end else begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= we_r ? {DW{1'b0}} : la_rdata_s;
          end
        end
        ST_ACC2: begin
          state_r     <= ST_RESP;
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= we_r ? {DW{1'b0}} : la_rdata_s;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign ram_sel   = ram_sel_r;
  // Reset must kill a write already presented in ACC2 before it commits on
  // the reset edge, so the registered strobe is gated by rst.
  assign ram_we    = ram_we_r && !rst;

endmodule

// File: tb/tb_lsu_ram_if.sv
module tb_lsu_ram_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_valid_na = 1'b0;
  logic        req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, ram_we;
  logic [31:0] rsp_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic        req_ready_na, rsp_valid_na, rsp_err_na, ram_we_na;
  logic [31:0] rsp_rdata_na, ram_addr_na, ram_wdata_na;
  logic [3:0]  ram_sel_na;
  logic [31:0] ram_rdata_na = 32'h5A5A5A5A;

  lsu_ram_if #(.DW(32), .AW(32), .MISALIGN_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_sel(ram_sel), .ram_we(ram_we), .ram_rdata(ram_rdata));

  lsu_ram_if #(.DW(32), .AW(32), .MISALIGN_EN(0)) dut_na (
    .clk(clk), .rst(rst), .req_valid(req_valid_na), .req_ready(req_ready_na),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_na),
    .rsp_rdata(rsp_rdata_na), .rsp_err(rsp_err_na), .ram_addr(ram_addr_na),
    .ram_wdata(ram_wdata_na), .ram_sel(ram_sel_na), .ram_we(ram_we_na),
    .ram_rdata(ram_rdata_na));

  // 16-word RAM with byte-lane writes; preload port has priority
  logic [31:0] ram_mem [0:15];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_data = 32'h0;
  int          na_we_cnt = 0;

  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_idx] <= pre_data;
    else if (ram_we)
      for (int l = 0; l < 4; l++)
        if (ram_sel[l]) ram_mem[ram_addr[3:0]][8*l +: 8] <= ram_wdata[8*l +: 8];
  end
  assign ram_rdata = ram_mem[ram_addr[3:0]];

  always @(posedge clk) if (ram_we_na) na_we_cnt <= na_we_cnt + 1;

  // Reference model: 64-byte little-endian memory
  logic [7:0] mdl [0:63];

  function automatic logic [31:0] model_exec(input logic we, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a,
                                             input logic [31:0] wd);
    int n;
    int b;
    logic [31:0] v;
    if (sz == 2'b11) return 32'h0;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      b = (int'(a[5:0]) + i) % 64;
      if (we) mdl[b] = wd[8*i +: 8];
      else    v[8*i +: 8] = mdl[b];
    end
    if (we) return 32'h0;
    if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Issue one request to the main DUT from a negedge; check every RAM cycle,
  // the latency and the response. Returns at the negedge inside RESP.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int o, n, exp_lat, lat;
    logic [3:0]  esel;
    logic [31:0] ewd;
    chk($sformatf("%s ready", nm), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    o = int'(a[1:0]);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    exp_lat = exp_err ? 1 : ((o + n > 4) ? 3 : 2);
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) lat = c;
      else if (c < exp_lat) begin
        esel = 4'b0000;
        for (int i = 0; i < n; i++)
          if (((o + i) >> 2) == c - 1) esel[(o + i) % 4] = 1'b1;
        ewd = (c == 1) ? (wd << (8 * o)) : (wd >> (8 * (4 - o)));
        chk($sformatf("%s addr%0d", nm, c), ram_addr, (a >> 2) + 32'(c - 1));
        chk($sformatf("%s sel%0d", nm, c), 32'(ram_sel), 32'(esel));
        chk($sformatf("%s wdata%0d", nm, c), ram_wdata, ewd);
        chk($sformatf("%s we%0d", nm, c), 32'(ram_we), 32'(we));
      end
    end
    chk($sformatf("%s latency", nm), 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      chk($sformatf("%s rdata", nm), rsp_rdata, exp_rd);
      chk($sformatf("%s err", nm), 32'(rsp_err), 32'(exp_err));
      chk($sformatf("%s resp_we", nm), 32'(ram_we), 32'd0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, e;
    logic        we_r;
    logic [1:0]  sz_r;
    logic        uns_r;
    logic [31:0] a_r, wd_r;

    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'h44332211, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h7, 32'h0,        32'hFFFFFF88, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h7, 32'h0,        32'h00000088, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 1'b0, 32'h2, 32'h0,        32'h00004433, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h2, 32'h0,        32'h66554433, 1'b0};
    tbl[5]  = '{1'b1, 2'b01, 1'b0, 32'h3, 32'h0000ABCD, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h0, 32'h0,        32'hCD332211, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 1'b0, 32'h4, 32'h0,        32'h887766AB, 1'b0};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 32'h0, 32'h0,        32'h00000000, 1'b1};
    tbl[9]  = '{1'b0, 2'b01, 1'b0, 32'h5, 32'h0,        32'h00007766, 1'b0};
    tbl[10] = '{1'b0, 2'b01, 1'b0, 32'h3, 32'h0,        32'hFFFFABCD, 1'b0};

    // Preload RAM and model while reset is held
    pre_we = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      w = (k == 0) ? 32'h44332211 : (k == 1) ? 32'h88776655 : $urandom;
      pre_idx = 4'(k); pre_data = w;
      for (int b = 0; b < 4; b++) mdl[4*k + b] = w[8*b +: 8];
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset ram_sel", 32'(ram_sel), 32'd0);
    chk("reset ram_addr", ram_addr, 32'd0);
    chk("reset ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset ready", 32'(req_ready), 32'd1);

    // Directed vectors, issued back to back through RESP
    for (int v = 0; v < 11; v++) begin
      void'(model_exec(tbl[v].we, tbl[v].sz, tbl[v].uns, tbl[v].a, tbl[v].wd));
      issue(tbl[v].we, tbl[v].sz, tbl[v].uns, tbl[v].a, tbl[v].wd,
            tbl[v].rd, tbl[v].err, $sformatf("vec%0d", v));
    end
    @(negedge clk);
    chk("idle rsp_valid", 32'(rsp_valid), 32'd0);

    // Randomized traffic against the byte-memory model
    for (int r = 0; r < 150; r++) begin
      we_r  = 1'($urandom);
      sz_r  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      uns_r = 1'($urandom);
      a_r   = 32'($urandom_range(0, 63));
      wd_r  = $urandom;
      e = model_exec(we_r, sz_r, uns_r, a_r, wd_r);
      issue(we_r, sz_r, uns_r, a_r, wd_r, e, sz_r == 2'b11, $sformatf("rnd%0d", r));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset during ACC2 of a crossing SW at 0x2
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h2; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid acc1 addr", ram_addr, 32'd0);
    chk("rstmid acc1 we", 32'(ram_we), 32'd1);
    @(negedge clk);
    chk("rstmid acc2 addr", ram_addr, 32'd1);
    chk("rstmid acc2 we", 32'(ram_we), 32'd1);
    rst = 1'b1;
    mdl[2] = 8'hEF; mdl[3] = 8'hBE;
    @(negedge clk);
    chk("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid rsp_rdata", rsp_rdata, 32'd0);
    chk("rstmid rsp_err", 32'(rsp_err), 32'd0);
    chk("rstmid ram_we", 32'(ram_we), 32'd0);
    chk("rstmid ram_sel", 32'(ram_sel), 32'd0);
    chk("rstmid ram_addr", ram_addr, 32'd0);
    chk("rstmid ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid ready", 32'(req_ready), 32'd1);
    chk("rstmid no rsp", 32'(rsp_valid), 32'd0);
    chk("rstmid word1", ram_mem[1], {mdl[7], mdl[6], mdl[5], mdl[4]});

    // MISALIGN_EN=0 instance: word-crossing and illegal sizes are errors
    for (int k = 0; k < 4; k++) begin
      req_we = (k == 2); req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
      req_size = (k == 0 || k == 2) ? 2'b10 : (k == 1) ? 2'b01 : 2'b11;
      req_addr = (k == 0) ? 32'h1 : (k == 1) ? 32'h3 : (k == 2) ? 32'h2 : 32'h4;
      req_valid_na = 1'b1;
      @(posedge clk); #1;
      req_valid_na = 1'b0;
      @(negedge clk);
      chk($sformatf("na%0d rsp_valid", k), 32'(rsp_valid_na), 32'd1);
      chk($sformatf("na%0d err", k), 32'(rsp_err_na), 32'd1);
      chk($sformatf("na%0d rdata", k), rsp_rdata_na, 32'd0);
    end
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h4; req_valid_na = 1'b1;
    @(posedge clk); #1;
    req_valid_na = 1'b0;
    @(negedge clk);
    chk("na aligned early", 32'(rsp_valid_na), 32'd0);
    @(negedge clk);
    chk("na aligned valid", 32'(rsp_valid_na), 32'd1);
    chk("na aligned err", 32'(rsp_err_na), 32'd0);
    chk("na aligned rdata", rsp_rdata_na, 32'h5A5A5A5A);
    @(negedge clk);
    chk("na no writes", 32'(na_we_cnt), 32'd0);

    // Final RAM contents against the model
    for (int k = 0; k < 16; k++)
      chk($sformatf("mem%0d", k), ram_mem[k],
          {mdl[4*k+3], mdl[4*k+2], mdl[4*k+1], mdl[4*k]});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
